detector_rr_sched: RTL and testbench
====================================

Name: detector_rr_sched

Overview:
Round-robin scheduler that time-shares one serial sequence-detector instance among NREQ serial requesters. The scheduler grants the detector to one requester for a fixed window, resets the detector before each window, and muxes that requester's bit stream onto the detector input. It counts the detector's match pulses and reports a per-window result. It sits between the serial lane sources and the shared detector.

Parameters:
NREQ, 4, number of requesters (2..8)
WINDOW, 6, RUN-state length in clock cycles per grant (2..255)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
req_in  input  NREQ  per-requester request level; held high until done_out for that requester
x_in  input  NREQ  per-requester serial data bit
det_y_in  input  1  shared detector match output (level, may stay high several cycles)
det_x_out  output  1  serial bit driven to shared detector
det_rst_n_out  output  1  active-low reset to shared detector
gnt_out  output  NREQ  one-hot grant, registered
busy_out  output  1  high in CLR/RUN/DONE
done_out  output  1  one-cycle pulse at window end
done_id_out  output  3  index of requester just served (valid with done_out)
hit_cnt_out  output  3  match count for window, saturating at 7 (valid with done_out)
aborted_out  output  1  window cut short by req drop (valid with done_out)

Behaviour:
- Reset (async, reset=1): state IDLE, rr pointer=0, gnt_out=0, busy_out=0, done_out=0, done_id_out=0, hit_cnt_out=0, aborted_out=0, det_x_out=1, det_rst_n_out=0. After reset release, det_rst_n_out=1 in IDLE.
- FSM states: IDLE, CLR, RUN, DONE.
- IDLE: if any req_in bit is high, select the first set bit searching from rr pointer upward with wrap. Next state CLR; gnt_out is one-hot for the winner from the next cycle. If no requests, stay in IDLE.
- CLR, 1 cycle: det_rst_n_out=0, det_x_out=1, clear window counter, hit counter and edge register.
- RUN, WINDOW cycles: det_x_out=x_in[granted], det_rst_n_out=1. Each 0->1 edge of det_y_in (sampled vs previous cycle) increments hit count, saturating at 7. Window counter reaching WINDOW-1 -> DONE.
- Abort: in RUN, if req_in[granted]=0, go to DONE next cycle with aborted_out=1. Hits counted up to that point are reported.
- DONE, 1 cycle: gnt_out=0, det_x_out=1, done_out=1, done_id_out=granted index, hit_cnt_out=count, aborted_out as above. rr pointer=(granted+1) mod NREQ. Next state IDLE.
- Latency: req_in rises at cycle t while IDLE -> gnt_out at t+1. done_out at t+2+WINDOW with no abort. Minimum re-grant spacing is WINDOW+3 cycles.
- hit_cnt_out and done_id_out hold their value until the next DONE. aborted_out is cleared in CLR.
- In IDLE, req_in bits that drop before selection are ignored. A req_in bit that drops after selection is caught by the abort rule in the first RUN cycle.
- Reset mid-window: immediate return to IDLE with all outputs at reset values. No done_out is produced.
- Only one requester active: it is re-granted every WINDOW+3 cycles.

Optional Feature:
Macro DET_SCHED_STATS_EN.
- Defined: adds input stat_sel (3 bits) and output stat_cnt_out (8 bits). Keeps one 8-bit saturating total-hit counter per requester, incremented by hit_cnt_out at each DONE (saturates at 255). stat_cnt_out is a combinational read of counter[stat_sel]. Reset clears all counters.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-RUN (assert reset at RUN cycle 3) -> gnt_out=0, busy_out=0, det_rst_n_out=0 immediately, no done_out.
- Single requester: req_in=4'b0001, x_in[0]=0,1 then idle-high, WINDOW=6 -> gnt_out=0001 at t+1, det_rst_n_out low one cycle, done_out at t+8, done_id_out=0, hit_cnt_out=1.
- All requesting: req_in=4'b1111 held -> grant order 0,1,2,3,0, done_out spaced 9 cycles apart.
- Saturation: det_y_in toggled every cycle during a WINDOW=20 run -> hit_cnt_out=7.
- Abort: req_in[2] dropped at RUN cycle 2 -> DONE next cycle, done_id_out=2, aborted_out=1, next grant goes to requester 3 if it is requesting.
- Stats (DET_SCHED_STATS_EN): three windows on requester 1 with 1, 2 and 3 hits -> stat_sel=1 gives stat_cnt_out=6.

Source files
------------

// File: rtl/detector_rr_sched_if.sv
// Port bundle between the round-robin detector scheduler and its lanes/detector.
// DET_SCHED_STATS_EN adds the statistics read port.
interface detector_rr_sched_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0] req_in;
    logic [NREQ-1:0] x_in;
    logic            det_y_in;
    logic            det_x_out;
    logic            det_rst_n_out;
    logic [NREQ-1:0] gnt_out;
    logic            busy_out;
    logic            done_out;
    logic [2:0]      done_id_out;
    logic [2:0]      hit_cnt_out;
    logic            aborted_out;
`ifdef DET_SCHED_STATS_EN
    logic [2:0]      stat_sel;
    logic [7:0]      stat_cnt_out;

    modport slave (
        input  req_in, x_in, det_y_in, stat_sel,
        output det_x_out, det_rst_n_out, gnt_out, busy_out, done_out,
               done_id_out, hit_cnt_out, aborted_out, stat_cnt_out
    );
    modport master (
        output req_in, x_in, det_y_in, stat_sel,
        input  det_x_out, det_rst_n_out, gnt_out, busy_out, done_out,
               done_id_out, hit_cnt_out, aborted_out, stat_cnt_out
    );
`else
    modport slave (
        input  req_in, x_in, det_y_in,
        output det_x_out, det_rst_n_out, gnt_out, busy_out, done_out,
               done_id_out, hit_cnt_out, aborted_out
    );
    modport master (
        output req_in, x_in, det_y_in,
        input  det_x_out, det_rst_n_out, gnt_out, busy_out, done_out,
               done_id_out, hit_cnt_out, aborted_out
    );
`endif
endinterface

// File: rtl/detector_rr_sched.sv
// Round-robin scheduler time-sharing one serial sequence detector among NREQ lanes.
// Define DET_SCHED_STATS_EN for per-requester saturating hit totals.
module detector_rr_sched #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WINDOW = 6
) (
    input logic                clock,
    input logic                reset,
    detector_rr_sched_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StClr, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [2:0]      rr_q, rr_d;
    logic [2:0]      idx_q, idx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [7:0]      win_q, win_d;
    logic [2:0]      hit_q, hit_d;
    logic            y_prev_q, y_prev_d;
    logic [2:0]      done_id_q, done_id_d;
    logic [2:0]      hit_out_q, hit_out_d;
    logic            aborted_q, aborted_d;
    logic            det_rst_n_q, det_rst_n_d;

    logic            found;
    logic [2:0]      pick;
    logic [NREQ-1:0] pick_oh;
    logic            req_gnt;
    logic            edge_hit;
    logic [2:0]      hit_inc;

    // Rotating priority: lowest requester at or above rr_q, else lowest overall.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        pick_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req_in[i] && (3'(i) >= rr_q)) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req_in[i]) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            pick_oh[i] = (3'(i) == pick);
        end
    end

    assign req_gnt  = |(bus.req_in & gnt_q);
    assign edge_hit = bus.det_y_in & ~y_prev_q;
    assign hit_inc  = (hit_q == 3'd7) ? 3'd7 : hit_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        idx_d       = idx_q;
        gnt_d       = gnt_q;
        win_d       = win_q;
        hit_d       = hit_q;
        y_prev_d    = y_prev_q;
        done_id_d   = done_id_q;
        hit_out_d   = hit_out_q;
        aborted_d   = aborted_q;
        det_rst_n_d = 1'b1;

        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d   = StClr;
                    idx_d     = pick;
                    gnt_d     = pick_oh;
                    aborted_d = 1'b0;
                end
            end
            StClr: begin
                win_d    = '0;
                hit_d    = '0;
                y_prev_d = 1'b0;
                state_d  = StRun;
            end
            StRun: begin
                y_prev_d = bus.det_y_in;
                win_d    = win_q + 8'd1;
                if (edge_hit) begin
                    hit_d = hit_inc;
                end
                if (!req_gnt) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end else if (win_q == 8'(WINDOW - 1)) begin
                    state_d = StDone;
                end
                // Latch the result on the way into DONE, including this cycle's edge.
                if (state_d == StDone) begin
                    gnt_d     = '0;
                    done_id_d = idx_q;
                    hit_out_d = hit_d;
                end
            end
            StDone: begin
                state_d = StIdle;
                rr_d    = (idx_q == 3'(NREQ - 1)) ? 3'd0 : idx_q + 3'd1;
            end
            default: state_d = StIdle;
        endcase

        det_rst_n_d = (state_d != StClr);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_q        <= '0;
            idx_q       <= '0;
            gnt_q       <= '0;
            win_q       <= '0;
            hit_q       <= '0;
            y_prev_q    <= 1'b0;
            done_id_q   <= '0;
            hit_out_q   <= '0;
            aborted_q   <= 1'b0;
            det_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            idx_q       <= idx_d;
            gnt_q       <= gnt_d;
            win_q       <= win_d;
            hit_q       <= hit_d;
            y_prev_q    <= y_prev_d;
            done_id_q   <= done_id_d;
            hit_out_q   <= hit_out_d;
            aborted_q   <= aborted_d;
            det_rst_n_q <= det_rst_n_d;
        end
    end

    assign bus.det_x_out     = (state_q == StRun) ? |(bus.x_in & gnt_q) : 1'b1;
    assign bus.det_rst_n_out = det_rst_n_q;
    assign bus.gnt_out       = gnt_q;
    assign bus.busy_out      = (state_q != StIdle);
    assign bus.done_out      = (state_q == StDone);
    assign bus.done_id_out   = done_id_q;
    assign bus.hit_cnt_out   = hit_out_q;
    assign bus.aborted_out   = aborted_q;

`ifdef DET_SCHED_STATS_EN
    logic [7:0] stat_q [NREQ];
    logic [7:0] stat_d [NREQ];
    logic [8:0] stat_sum;
    logic [7:0] stat_rd;

    always_comb begin
        stat_sum = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_d[i] = stat_q[i];
            if ((state_q == StDone) && (idx_q == 3'(i))) begin
                stat_sum  = {1'b0, stat_q[i]} + {6'b0, hit_out_q};
                stat_d[i] = stat_sum[8] ? 8'hff : stat_sum[7:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    always_comb begin
        stat_rd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.stat_sel == 3'(i)) begin
                stat_rd = stat_q[i];
            end
        end
    end

    assign bus.stat_cnt_out = stat_rd;
`endif

endmodule

// File: tb/tb_detector_rr_sched.sv
// Bench for detector_rr_sched: directed scenarios and randomized windows checked
// against a per-window model (rotating priority, edge counting, timing).
module tb_detector_rr_sched;
    localparam int unsigned N    = 4;
    localparam int unsigned W    = 6;
    localparam int unsigned WSAT = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Model state
    int mptr = 0;
    int last_id = 0;
    int last_hits = 0;
    int last_done = -1;
    int mstat [N];

    detector_rr_sched_if #(.NREQ(N)) bus ();
    detector_rr_sched_if #(.NREQ(N)) bus2 ();

    detector_rr_sched #(.NREQ(N), .WINDOW(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    detector_rr_sched #(.NREQ(N), .WINDOW(WSAT)) dut_sat (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, bus.busy_out, 0);
        chk({tag, "_gnt"}, bus.gnt_out, 0);
        chk({tag, "_done"}, bus.done_out, 0);
        chk({tag, "_rstn"}, bus.det_rst_n_out, 1);
        chk({tag, "_detx"}, bus.det_x_out, 1);
        chk({tag, "_id_hold"}, bus.done_id_out, last_id);
        chk({tag, "_hit_hold"}, bus.hit_cnt_out, last_hits);
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE after DONE.
    // pulses < 0: random det_y; otherwise that many isolated pulses at even RUN cycles.
    task automatic run_window(input logic [N-1:0] req, input int abort_at, input int pulses);
        int   win;
        int   hits;
        int   t_req;
        logic prev;
        logic y;
        logic ab;
        win = -1;
        for (int off = 0; off < N; off++) begin
            int k;
            k = (mptr + off) % N;
            if (win < 0 && req[k]) win = k;
        end
        bus.req_in   = req;
        bus.x_in     = N'($urandom);
        bus.det_y_in = 1'($urandom);
        t_req        = cyc;
        mid();
        chk_idle("req_cycle");

        step();
        bus.x_in     = N'($urandom);
        bus.det_y_in = 1'($urandom);
        mid();
        chk("clr_gnt", bus.gnt_out, 32'(1) << win);
        chk("clr_rstn", bus.det_rst_n_out, 0);
        chk("clr_detx", bus.det_x_out, 1);
        chk("clr_busy", bus.busy_out, 1);
        chk("clr_aborted", bus.aborted_out, 0);
        chk("clr_done", bus.done_out, 0);

        hits = 0;
        prev = 1'b0;
        ab   = 1'b0;
        for (int r = 0; r < W; r++) begin
            step();
            bus.x_in = N'($urandom);
            y = (pulses < 0) ? 1'($urandom) : ((r % 2 == 0) && (r / 2 < pulses));
            bus.det_y_in = y;
            if (r == abort_at) bus.req_in[win] = 1'b0;
            mid();
            chk("run_detx", bus.det_x_out, bus.x_in[win]);
            chk("run_rstn", bus.det_rst_n_out, 1);
            chk("run_gnt", bus.gnt_out, 32'(1) << win);
            chk("run_done", bus.done_out, 0);
            if (y && !prev && hits < 7) hits++;
            prev = y;
            if (r == abort_at) begin
                ab = 1'b1;
                break;
            end
        end

        step();
        bus.x_in     = N'($urandom);
        bus.det_y_in = 1'($urandom);
        mid();
        chk("done_pulse", bus.done_out, 1);
        chk("done_id", bus.done_id_out, win);
        chk("done_hits", bus.hit_cnt_out, hits);
        chk("done_aborted", bus.aborted_out, ab);
        chk("done_gnt", bus.gnt_out, 0);
        chk("done_detx", bus.det_x_out, 1);
        chk("done_busy", bus.busy_out, 1);
        if (!ab) chk("done_latency", cyc - t_req, 2 + W);
        last_done = cyc;
        mptr      = (win + 1) % N;
        last_id   = win;
        last_hits = hits;
        mstat[win] = (mstat[win] + hits > 255) ? 255 : mstat[win] + hits;
        step();
    endtask

    initial begin
        int prev_done;
        int sat_hits;
        logic y;
        logic prev;
        for (int i = 0; i < N; i++) mstat[i] = 0;
        bus.req_in    = '0;
        bus.x_in      = '0;
        bus.det_y_in  = 1'b0;
        bus2.req_in   = '0;
        bus2.x_in     = '0;
        bus2.det_y_in = 1'b0;
`ifdef DET_SCHED_STATS_EN
        bus.stat_sel  = '0;
        bus2.stat_sel = '0;
`endif

        // Reset values while reset is held
        #1;
        chk("rst_gnt", bus.gnt_out, 0);
        chk("rst_busy", bus.busy_out, 0);
        chk("rst_done", bus.done_out, 0);
        chk("rst_id", bus.done_id_out, 0);
        chk("rst_hits", bus.hit_cnt_out, 0);
        chk("rst_aborted", bus.aborted_out, 0);
        chk("rst_detx", bus.det_x_out, 1);
        chk("rst_rstn", bus.det_rst_n_out, 0);
        step();
        step();
        reset = 1'b0;
        step();
        mid();
        chk("idle_rstn", bus.det_rst_n_out, 1);
        step();

        // All requesting: order 0,1,2,3,0 with WINDOW+3 spacing
        prev_done = -1;
        for (int i = 0; i < 5; i++) begin
            run_window(4'b1111, -1, -1);
            chk("rr_order", last_id, i % N);
            if (prev_done >= 0) chk("done_spacing", last_done - prev_done, W + 3);
            prev_done = last_done;
        end

        // Single requester, one detector hit
        run_window(4'b0001, -1, 1);

        // Abort requester 2 at RUN cycle 2; next grant goes to 3
        run_window(4'b0100, 2, -1);
        run_window(4'b1011, -1, -1);
        chk("abort_next", last_id, 3);

        // Reset in RUN cycle 3
        bus.req_in = 4'b0010;
        for (int i = 0; i < 5; i++) step();
        mid();
        chk("pre_rst_busy", bus.busy_out, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", bus.gnt_out, 0);
        chk("mid_rst_busy", bus.busy_out, 0);
        chk("mid_rst_rstn", bus.det_rst_n_out, 0);
        chk("mid_rst_done", bus.done_out, 0);
        chk("mid_rst_hits", bus.hit_cnt_out, 0);
        chk("mid_rst_id", bus.done_id_out, 0);
        bus.req_in = '0;
        step();
        reset = 1'b0;
        mptr = 0;
        last_id = 0;
        last_hits = 0;
        for (int i = 0; i < N; i++) mstat[i] = 0;
        for (int i = 0; i < 12; i++) begin
            mid();
            chk("post_rst_done", bus.done_out, 0);
            chk("post_rst_busy", bus.busy_out, 0);
            step();
        end

        // Three windows on requester 1 with 1, 2 and 3 hits
        run_window(4'b0010, -1, 1);
        run_window(4'b0010, -1, 2);
        run_window(4'b0010, -1, 3);
`ifdef DET_SCHED_STATS_EN
        bus.stat_sel = 3'd1;
        #1;
        chk("stat_req1", bus.stat_cnt_out, 6);
        chk("stat_req1_model", bus.stat_cnt_out, mstat[1]);
`endif

        // Randomized windows with idle gaps and occasional aborts
        for (int e = 0; e < 40; e++) begin
            int ab_at;
            if ($urandom_range(0, 2) == 0) begin
                int gap;
                gap = $urandom_range(1, 3);
                for (int k = 0; k < gap; k++) begin
                    bus.req_in = '0;
                    mid();
                    chk_idle("gap");
                    step();
                end
            end
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            run_window(N'($urandom_range(1, 15)), ab_at, -1);
        end
        bus.req_in = '0;

        // Saturation on the WINDOW=20 instance: det_y toggles every RUN cycle
        bus2.req_in = 4'b0001;
        step();
        sat_hits = 0;
        prev = 1'b0;
        y = 1'b0;
        for (int r = 0; r < WSAT; r++) begin
            step();
            y = ~y;
            bus2.det_y_in = y;
            if (y && !prev && sat_hits < 7) sat_hits++;
            prev = y;
        end
        step();
        bus2.det_y_in = 1'b0;
        bus2.req_in = '0;
        mid();
        chk("sat_done", bus2.done_out, 1);
        chk("sat_hits", bus2.hit_cnt_out, sat_hits);
        chk("sat_hits_7", bus2.hit_cnt_out, 7);
        chk("sat_id", bus2.done_id_out, 0);
        step();

`ifdef DET_SCHED_STATS_EN
        for (int s = 0; s < N; s++) begin
            bus.stat_sel = 3'(s);
            #1;
            chk("stat_total", bus.stat_cnt_out, mstat[s]);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
